// File: rtl/spi_flash_xfer_seq_if.sv
// Request, data-byte and SPI pin bundle for the serial flash transaction sequencer.
// slave is the sequencer's view; master is the requester/flash-side view.
interface spi_flash_xfer_seq_if #(
  parameter int unsigned LEN_W = 13
);
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned BYTE_W = 8;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_nrw_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [LEN_W-1:0]  req_len_i;
  logic [BYTE_W-1:0] wr_data_i;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [BYTE_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic              sclk_o;
  logic              cs_n_o;
  logic              mosi_o;
  logic              miso_i;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  req_valid_i, req_nrw_i, req_addr_i, req_len_i,
    input  wr_data_i, wr_valid_i, rd_ready_i, miso_i,
    output req_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
    output sclk_o, cs_n_o, mosi_o, busy_o, done_o
  );

  modport master (
    output req_valid_i, req_nrw_i, req_addr_i, req_len_i,
    output wr_data_i, wr_valid_i, rd_ready_i, miso_i,
    input  req_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
    input  sclk_o, cs_n_o, mosi_o, busy_o, done_o
  );
endinterface

// File: rtl/spi_flash_xfer_seq.sv
// Serial flash transaction sequencer: opcode, 24-bit address, optional dummy byte and
// N data bytes clocked out in SPI mode 0, with byte-level valid/ready flow control.
module spi_flash_xfer_seq #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [7:0]  OPC_READ = 8'h0B,
  parameter logic [7:0]  OPC_PROG = 8'h02,
  parameter int unsigned LEN_W    = 13
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  spi_flash_xfer_seq_if.slave  bus
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned ADDR_W = 24;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         sh_q, sh_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               nrw_q, nrw_d;
  logic               fetch_q, fetch_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;
  logic               rd_valid_q, rd_valid_d;
  logic               wr_ready_q, wr_ready_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;
  logic               done_q, done_d;
  logic               div_end;
  logic [7:0]         opc;

  // Next-state: the shift states share one bit engine; byte boundaries pick the next phase.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    hdr_cnt_d   = hdr_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    rd_data_d   = rd_data_q;
    nrw_d       = nrw_q;
    fetch_d     = fetch_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    rd_valid_d  = rd_valid_q;
    wr_ready_d  = 1'b0;
    busy_d      = busy_q;
    req_ready_d = req_ready_q;
    done_d      = 1'b0;
    div_end     = (div_q == DIV_LAST);
    opc         = bus.req_nrw_i ? OPC_PROG : OPC_READ;

    if (rd_valid_q && bus.rd_ready_i) rd_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i && req_ready_q) begin
          state_d     = S_CS_SETUP;
          cs_n_d      = 1'b0;
          busy_d      = 1'b1;
          req_ready_d = 1'b0;
          nrw_d       = bus.req_nrw_i;
          addr_d      = bus.req_addr_i;
          byte_cnt_d  = bus.req_len_i;
          sh_d        = opc;
          mosi_d      = opc[7];
          div_d       = '0;
          bit_cnt_d   = '0;
          fetch_d     = 1'b0;
        end
      end

      // Doubles as the low phase of the first opcode bit.
      S_CS_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_CMD;
        end else begin
          div_d = DIV_W'(div_q + DIV_W'(1));
        end
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (fetch_q) begin
          // Byte boundary in DATA: wait for a write byte or for the previous read byte to drain.
          if (nrw_q) begin
            if (bus.wr_valid_i) begin
              wr_ready_d = 1'b1;
              sh_d       = bus.wr_data_i;
              mosi_d     = bus.wr_data_i[7];
              fetch_d    = 1'b0;
              div_d      = '0;
            end
          end else if (!rd_valid_q || bus.rd_ready_i) begin
            sh_d    = '0;
            mosi_d  = 1'b0;
            fetch_d = 1'b0;
            div_d   = '0;
          end
        end else if (!div_end) begin
          div_d = DIV_W'(div_q + DIV_W'(1));
        end else if (!sclk_q) begin
          div_d  = '0;
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], bus.miso_i};
        end else begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
            sh_d      = {sh_q[6:0], 1'b0};
            mosi_d    = sh_q[6];
          end else begin
            bit_cnt_d = '0;
            unique case (state_q)
              S_CMD: begin
                state_d   = S_ADDR;
                hdr_cnt_d = '0;
                sh_d      = addr_q[23:16];
                mosi_d    = addr_q[23];
                addr_d    = {addr_q[15:0], 8'h00};
              end
              S_ADDR: begin
                if (hdr_cnt_q != 2'd2) begin
                  hdr_cnt_d = 2'(hdr_cnt_q + 2'd1);
                  sh_d      = addr_q[23:16];
                  mosi_d    = addr_q[23];
                  addr_d    = {addr_q[15:0], 8'h00};
                end else if (!nrw_q) begin
                  state_d = S_DUMMY;
                  sh_d    = '0;
                  mosi_d  = 1'b0;
                end else if (byte_cnt_q == LEN_W'(0)) begin
                  state_d = S_CS_HOLD;
                  mosi_d  = 1'b0;
                end else begin
                  state_d = S_DATA;
                  fetch_d = 1'b1;
                end
              end
              S_DUMMY: begin
                if (byte_cnt_q == LEN_W'(0)) begin
                  state_d = S_CS_HOLD;
                end else begin
                  state_d = S_DATA;
                  fetch_d = 1'b1;
                end
              end
              default: begin
                if (!nrw_q) begin
                  rd_data_d  = rx_q;
                  rd_valid_d = 1'b1;
                end
                if (byte_cnt_q == LEN_W'(1)) begin
                  state_d = S_CS_HOLD;
                  mosi_d  = 1'b0;
                end else begin
                  byte_cnt_d = LEN_W'(byte_cnt_q - LEN_W'(1));
                  fetch_d    = 1'b1;
                end
              end
            endcase
          end
        end
      end

      S_CS_HOLD: begin
        if (div_end) begin
          div_d       = '0;
          cs_n_d      = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          div_d = DIV_W'(div_q + DIV_W'(1));
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      hdr_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      nrw_q       <= 1'b0;
      fetch_q     <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_cnt_q   <= hdr_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      nrw_q       <= nrw_d;
      fetch_q     <= fetch_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.wr_ready_o  = wr_ready_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.sclk_o      = sclk_q;
  assign bus.cs_n_o      = cs_n_q;
  assign bus.mosi_o      = mosi_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_spi_flash_xfer_seq.sv
// Directed bench for spi_flash_xfer_seq: table of transactions with a bit-level flash model,
// plus a hand-written mid-address reset sequence.
module tb_spi_flash_xfer_seq;

  localparam int unsigned DIV = 2;

  typedef struct {
    logic        nrw;
    logic [23:0] addr;
    int          len;
    logic [31:0] data;
    int          stall_byte;
    int          stall_cyc;
    int          hold_idx;
    int          hold_cyc;
    int          exp_rises;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  spi_flash_xfer_seq_if #(.LEN_W(13)) bus ();

  spi_flash_xfer_seq #(
    .CLK_DIV (DIV),
    .OPC_READ(8'h0B),
    .OPC_PROG(8'h02),
    .LEN_W   (13)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Flash model: log MOSI on every SCLK rise, serve MISO bits MSB first after the header.
  int          rise_cnt = 0;
  logic        mosi_bits [0:1023];
  int          base_rise = 0;
  int          cur_len = 0;
  int          hdr_bits = 40;
  logic [31:0] cur_rd = '0;
  int          rel_c;

  always @(posedge bus.sclk_o) begin
    if (rise_cnt < 1024) mosi_bits[rise_cnt] <= bus.mosi_o;
    rise_cnt <= rise_cnt + 1;
  end

  always_comb begin
    rel_c = rise_cnt - base_rise - hdr_bits;
    bus.miso_i = 1'b0;
    if (rel_c >= 0 && rel_c < 8 * cur_len && rel_c < 32) bus.miso_i = cur_rd[31 - rel_c];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int base, rel, cyc, tail, boundary, bdy_age, stall_left, hold_left;
    int wr_idx, rd_got, done_cnt, wr_pulses, setup_cyc, hold_cnt, nbytes;
    logic stall_ok, freeze_ok, cs_at_done_ok;
    logic [7:0] got_rd [4];
    logic [7:0] e, g;
    logic [23:0] a;
    logic [31:0] d;
    base = rise_cnt; base_rise = base; cur_rd = v.data; cur_len = v.len;
    hdr_bits = v.nrw ? 32 : 40;
    boundary = 8 * (4 + v.stall_byte);
    bdy_age = 0; stall_left = v.stall_cyc; hold_left = v.hold_cyc;
    wr_idx = 0; rd_got = 0; done_cnt = 0; wr_pulses = 0; setup_cyc = 0; hold_cnt = 0;
    stall_ok = 1'b1; freeze_ok = 1'b1; cs_at_done_ok = 1'b1; cyc = 0; tail = 0;
    a = v.addr; d = v.data;
    for (int i = 0; i < 4; i++) got_rd[i] = '0;

    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_nrw_i = v.nrw; bus.req_addr_i = v.addr;
    bus.req_len_i = 13'(v.len); bus.rd_ready_i = 1'b1; bus.wr_valid_i = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk($sformatf("%s accept_busy", nm), 32'(bus.busy_o), 32'd1);

    while (tail < 5 && cyc < 3000) begin
      rel = rise_cnt - base;
      // Request poke while busy must be ignored.
      if (cyc == 6) begin
        bus.req_valid_i = 1'b1; bus.req_nrw_i = ~v.nrw;
        chk($sformatf("%s ready_while_busy", nm), 32'(bus.req_ready_o), 32'd0);
      end else begin
        bus.req_valid_i = 1'b0;
      end
      if (!bus.cs_n_o && rel == 0) setup_cyc++;
      if (!bus.cs_n_o && !bus.sclk_o && rel == v.exp_rises) hold_cnt++;
      if (bus.wr_ready_o) begin wr_pulses++; wr_idx++; end
      if (v.nrw && wr_idx == v.stall_byte && stall_left > 0 && rel == boundary) begin
        bdy_age++;
        if (bdy_age > DIV) begin
          stall_left--;
          if (bus.sclk_o || bus.cs_n_o) stall_ok = 1'b0;
        end
      end
      bus.wr_valid_i = v.nrw && wr_idx < v.len && !(wr_idx == v.stall_byte && stall_left > 0);
      if (wr_idx < 4) bus.wr_data_i = d[31 - 8 * wr_idx -: 8];
      if (bus.rd_valid_o && rd_got == v.hold_idx && hold_left > 0) begin
        bus.rd_ready_i = 1'b0;
        hold_left--;
        if (bus.sclk_o || rel != 40 + 8 * (v.hold_idx + 1) || bus.rd_data_o != d[31 - 8 * v.hold_idx -: 8])
          freeze_ok = 1'b0;
      end else begin
        bus.rd_ready_i = 1'b1;
        if (bus.rd_valid_o) begin
          if (rd_got < 4) got_rd[rd_got] = bus.rd_data_o;
          rd_got++;
        end
      end
      if (bus.done_o) begin
        done_cnt++;
        if (!bus.cs_n_o) cs_at_done_ok = 1'b0;
      end
      if (done_cnt > 0) tail++;
      @(negedge clk);
      cyc++;
    end
    bus.req_valid_i = 1'b0; bus.wr_valid_i = 1'b0; bus.rd_ready_i = 1'b1;

    chk($sformatf("%s done_pulses", nm), 32'(done_cnt), 32'd1);
    chk($sformatf("%s cs_high_at_done", nm), 32'(cs_at_done_ok), 32'd1);
    chk($sformatf("%s sclk_rises", nm), 32'(rise_cnt - base), 32'(v.exp_rises));
    chk($sformatf("%s cs_setup_cycles", nm), 32'(setup_cyc), 32'(DIV));
    chk($sformatf("%s cs_hold_cycles", nm), 32'(hold_cnt), 32'(DIV));
    chk($sformatf("%s wr_ready_pulses", nm), 32'(wr_pulses), 32'(v.nrw ? v.len : 0));
    chk($sformatf("%s rd_bytes", nm), 32'(rd_got), 32'(v.nrw ? 0 : v.len));
    nbytes = 4 + (v.nrw ? 0 : 1) + v.len;
    for (int i = 0; i < nbytes; i++) begin
      if (i == 0) e = v.nrw ? 8'h02 : 8'h0B;
      else if (i < 4) e = a[23 - 8 * (i - 1) -: 8];
      else if (!v.nrw) e = 8'h00;
      else e = d[31 - 8 * (i - 4) -: 8];
      g = '0;
      for (int j = 0; j < 8; j++)
        if (base + 8 * i + j < 1024) g[7 - j] = mosi_bits[base + 8 * i + j];
      chk($sformatf("%s mosi_byte%0d", nm, i), 32'(g), 32'(e));
    end
    if (!v.nrw)
      for (int i = 0; i < v.len && i < 4; i++)
        chk($sformatf("%s rd_data%0d", nm, i), 32'(got_rd[i]), 32'(d[31 - 8 * i -: 8]));
    if (v.stall_byte >= 0) begin
      chk($sformatf("%s stall_sclk_low_cs_low", nm), 32'(stall_ok), 32'd1);
      chk($sformatf("%s stall_elapsed", nm), 32'(stall_left), 32'd0);
    end
    if (v.hold_idx >= 0) begin
      chk($sformatf("%s rd_hold_frozen", nm), 32'(freeze_ok), 32'd1);
      chk($sformatf("%s rd_hold_elapsed", nm), 32'(hold_left), 32'd0);
    end
    chk($sformatf("%s idle_busy", nm), 32'(bus.busy_o), 32'd0);
    chk($sformatf("%s idle_ready", nm), 32'(bus.req_ready_o), 32'd1);
  endtask

  vec_t vecs [5];

  initial begin
    int base, waited;
    logic no_done;
    vecs[0] = '{1'b0, 24'h123456, 2, 32'hA53C0000, -1, 0, -1, 0, 56};
    vecs[1] = '{1'b1, 24'h0000FF, 3, 32'h11223300, -1, 0, -1, 0, 56};
    vecs[2] = '{1'b1, 24'hABCDEF, 2, 32'h5AC30000, 1, 20, -1, 0, 48};
    vecs[3] = '{1'b0, 24'h000100, 3, 32'h817EFF00, -1, 0, 0, 50, 64};
    vecs[4] = '{1'b0, 24'hFFFFFF, 0, 32'h00000000, -1, 0, -1, 0, 40};

    bus.req_valid_i = 1'b0; bus.req_nrw_i = 1'b0; bus.req_addr_i = '0; bus.req_len_i = '0;
    bus.wr_data_i = '0; bus.wr_valid_i = 1'b0; bus.rd_ready_i = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("reset cs_n", 32'(bus.cs_n_o), 32'd1);
    chk("reset sclk", 32'(bus.sclk_o), 32'd0);
    chk("reset mosi", 32'(bus.mosi_o), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset done", 32'(bus.done_o), 32'd0);
    chk("reset rd_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("reset wr_ready", 32'(bus.wr_ready_o), 32'd0);
    chk("reset rd_data", 32'(bus.rd_data_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("T%0d", i + 1));

    // Reset in the middle of the address phase aborts at once with no done pulse.
    base = rise_cnt; base_rise = base; cur_len = 2; cur_rd = 32'hDEAD0000; hdr_bits = 40;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_nrw_i = 1'b0; bus.req_addr_i = 24'h654321; bus.req_len_i = 13'd2;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    waited = 0;
    while (rise_cnt - base < 13 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("T6 reached_addr_phase", 32'(waited < 500), 32'd1);
    chk("T6 cs_low_before_reset", 32'(bus.cs_n_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("T6 reset cs_n", 32'(bus.cs_n_o), 32'd1);
    chk("T6 reset sclk", 32'(bus.sclk_o), 32'd0);
    chk("T6 reset busy", 32'(bus.busy_o), 32'd0);
    chk("T6 reset req_ready", 32'(bus.req_ready_o), 32'd1);
    no_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done_o) no_done = 1'b0;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done_o || !bus.cs_n_o) no_done = 1'b0;
    end
    chk("T6 no_done_after_abort", 32'(no_done), 32'd1);
    run_txn(vecs[0], "T6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
